// File: rtl/pc_unit_pkg.sv
// Shared control opcodes for the program-counter unit.
// PC source selects and link-stack push source selects, both driven by the control unit.
package pc_unit_pkg;

  typedef enum logic [2:0] {
    PcInc    = 3'd0,
    PcSysbus = 3'd1,
    PcAluOut = 3'd2,
    PcInt    = 3'd3,
    PcPop    = 3'd4
  } pc_select_t;

  typedef enum logic {
    LrSys = 1'b0,
    LrPc  = 1'b1
  } Lr_select_t;

endpackage

// File: rtl/lr_stack.sv
// Shift-register link stack. Entry 0 is the top. A push when full drops the oldest entry.
// Push, pop and push-with-pop all take one edge. Overflow and underflow are single-cycle pulses.
module lr_stack
  import pc_unit_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LR_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_dat,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam int CW = $clog2(LR_DEPTH + 1);

  logic [LR_DEPTH-1:0][WIDTH-1:0] entry_q, entry_d;
  logic [CW-1:0]                  count_q, count_d;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(LR_DEPTH));
  assign top   = empty ? '0 : entry_q[0];

  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    ovf     = 1'b0;
    unf     = pop && empty;
    if (push && pop && !empty) begin
      // The pop consumes the old top, so the push simply overwrites it.
      entry_d[0] = push_dat;
    end else if (push) begin
      for (int i = LR_DEPTH - 1; i > 0; i--) begin
        entry_d[i] = entry_q[i-1];
      end
      entry_d[0] = push_dat;
      if (full) begin
        ovf = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (pop && !empty) begin
      for (int i = 0; i < LR_DEPTH - 1; i++) begin
        entry_d[i] = entry_q[i+1];
      end
      entry_d[LR_DEPTH-1] = '0;
      count_d             = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
      count_q <= '0;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with increment/bus/ALU/interrupt/pop load paths and a nested link stack.
// One-edge latency for loads, pushes and pops. Bus drive, carry and stack top are combinational.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter int               LR_DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] INT_VECTOR   = WIDTH'('h0004)
) (
  input  logic             Clock,
  input  logic             nReset,
  inout  wire  [WIDTH-1:0] SysBus,
  input  logic [WIDTH-1:0] ALU,
  input  logic             PcWe,
  input  pc_select_t       PcSel,
  input  logic             PcIncCin,
  input  logic             PcEn,
  input  logic             LrWe,
  input  Lr_select_t       LrSel,
  input  logic             LrEn,
  output logic [WIDTH-1:0] Pc,
  output logic             PcIncCout,
  output logic [WIDTH-1:0] LrTop,
  output logic             LrEmpty,
  output logic             LrFull,
  output logic             StackErr
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] pc1;
  logic [WIDTH-1:0] lr_top;
  logic [WIDTH-1:0] push_dat;
  logic             pop_req, int_push, push_req;
  logic             lr_ovf, lr_unf;

  assign {PcIncCout, pc1} = {1'b0, pc_q} + {{WIDTH{1'b0}}, PcIncCin};

  assign pop_req  = PcWe && (PcSel == PcPop);
  assign int_push = PcWe && (PcSel == PcInt);
  // Interrupt entry saves the interrupted address and overrides any explicit push.
  assign push_req = int_push || LrWe;
  assign push_dat = int_push          ? pc_q :
                    (LrSel == LrPc)   ? pc1  : SysBus;

  lr_stack #(
    .WIDTH    (WIDTH),
    .LR_DEPTH (LR_DEPTH)
  ) u_lr_stack (
    .clk      (Clock),
    .rst_n    (nReset),
    .push     (push_req),
    .pop      (pop_req),
    .push_dat (push_dat),
    .top      (lr_top),
    .empty    (LrEmpty),
    .full     (LrFull),
    .ovf      (lr_ovf),
    .unf      (lr_unf)
  );

  always_comb begin
    pc_d  = pc_q;
    err_d = err_q || lr_ovf || lr_unf;
    if (PcWe) begin
      unique case (PcSel)
        PcInc:    pc_d = pc1;
        PcSysbus: pc_d = SysBus;
        PcAluOut: pc_d = ALU;
        PcInt:    pc_d = INT_VECTOR;
        PcPop:    pc_d = lr_top;
        default:  pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pc_q  <= RESET_VECTOR;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign SysBus   = PcEn ? pc_q : (LrEn ? lr_top : {WIDTH{1'bz}});
  assign Pc       = pc_q;
  assign LrTop    = lr_top;
  assign StackErr = err_q;

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit: a WIDTH-bit PC register with increment, bus, ALU, interrupt-vector and return-from-stack load paths. It also holds a LR_DEPTH-entry link-register stack for nested calls and interrupts. Sits in the datapath between SysBus, the ALU output and the control unit, which drives all selects and enables. It replaces the single-bit PC/LR slice with a full-width block that supports nesting.

## Interface
- WIDTH, 16, PC/LR/bus width in bits
- LR_DEPTH, 4, link-stack entries (>=2)
- RESET_VECTOR, 0, PC value after reset
- INT_VECTOR, 'h0004, PC value loaded on interrupt entry

- Clock  in  1  system clock, all state updates on rising edge
- nReset  in  1  asynchronous, active-low reset
- SysBus  inout  WIDTH  shared bus; driven only when PcEn or LrEn, else 'z
- ALU  in  WIDTH  ALU result
- PcWe  in  1  PC load enable
- PcSel  in  pc_select_t  PC source: PcInc, PcSysbus, PcAluOut, PcInt, PcPop
- PcIncCin  in  1  increment amount (0/1) on the PcInc path and for the LrPc push value
- PcEn  in  1  drive Pc onto SysBus
- LrWe  in  1  push onto link stack
- LrSel  in  Lr_select_t  push source: LrSys (SysBus), LrPc (Pc+PcIncCin)
- LrEn  in  1  drive stack top onto SysBus
- Pc  out  WIDTH  current PC
- PcIncCout  out  1  carry out of Pc+PcIncCin
- LrTop  out  WIDTH  top-of-stack, 0 when empty
- LrEmpty, LrFull  out  1  stack occupancy flags
- StackErr  out  1  sticky overflow/underflow flag

## Operation
- Pc1 = Pc + PcIncCin, modulo 2^WIDTH. The all-ones value with PcIncCin=1 wraps to 0 and sets PcIncCout=1.
- When PcWe=1, Pc loads on the next edge:
  - PcInc: Pc1
  - PcSysbus: SysBus
  - PcAluOut: ALU
  - PcInt: INT_VECTOR
  - PcPop: LrTop
- PcWe=0 holds Pc.
- Push (LrWe=1): the LrSel source value goes to the top and count increments.
- PcInt with PcWe=1 auto-pushes the current Pc, which is the interrupted address. LrWe is ignored in that cycle.
- Pop: PcSel=PcPop with PcWe=1 pops the top into Pc and count decrements.
- Push and pop in the same cycle: the top is replaced by the push value and count is unchanged.
- Push when full: the oldest entry is discarded, the new value becomes the top, count stays LR_DEPTH, and StackErr is set.
- Pop when empty: Pc loads 0, count stays 0, and StackErr is set.
- StackErr clears only on reset.
- SysBus drive:
  - PcEn alone drives Pc.
  - LrEn alone drives LrTop.
  - If both are set, Pc wins.
  - If neither is set, the bus is 'z.
  - When driving SysBus, the block ignores its own SysBus value as a load source. Control never asserts PcEn together with PcSysbus/LrSys.

## Timing
- Reset (asynchronous, any time including mid-push): Pc=RESET_VECTOR, count=0, all entries 0, LrEmpty=1, LrFull=0, StackErr=0, SysBus 'z.
- Single-cycle latency: Pc, LrTop and the flags reflect a load/push/pop after the rising edge that samples it.
- SysBus, PcIncCout and LrTop are combinational from registers and controls. SysBus is valid within the same cycle that PcEn/LrEn rise.
- Flags are derived from the registered count, so there is no glitch path from inputs.

## Structure
- Shared package opcodes: pc_select_t {PcInc, PcSysbus, PcAluOut, PcInt, PcPop} and Lr_select_t {LrSys, LrPc}. Extend the existing enums; do not duplicate them.
- Sub-module lr_stack #(WIDTH, LR_DEPTH): shift-register stack with push/pop/replace, count, full/empty and overflow/underflow pulses.
- pc_unit: PC register, source mux, incrementer, interrupt auto-push, StackErr register and bus drivers.

## Test plan
Defaults WIDTH=16, LR_DEPTH=4.
- Reset, then PcEn=1 → SysBus=0x0000, LrEmpty=1, StackErr=0. Pulsing nReset mid-push returns all outputs to reset values.
- PcWe=1, PcSel=PcInc, PcIncCin=1 for 3 cycles → Pc=3. Then PcIncCin=0 → Pc stays 3. Pc=0xFFFF with PcIncCin=1 → PcIncCout=1, next Pc=0x0000.
- Load via the other sources:
  - SysBus=0x1234 with PcSysbus → Pc=0x1234.
  - ALU=0xBEEF with PcAluOut → Pc=0xBEEF.
  - PcInt at Pc=0x0100 → Pc=0x0004, LrTop=0x0100.
- Nested calls: push LrPc at Pc=0x10, 0x20, 0x30 with PcIncCin=1 → LrTop=0x31. Three PcPops → Pc=0x31, 0x21, 0x11 and LrEmpty=1.
- Five pushes 1..5 → LrFull=1, StackErr=1. Four pops yield 5, 4, 3, 2. A further pop → Pc=0, StackErr stays 1.
- PcEn=1 and LrEn=1 with Pc=0xAAAA, LrTop=0x5555 → SysBus=0xAAAA. Both low → SysBus='z. Simultaneous push 0x77 and pop → count unchanged, LrTop=0x77.
